// File: rtl/collision_scorer.sv
// collision_scorer: per-frame shot/player vs enemy hit detection, BCD score, lives and scene sequencing.
module collision_scorer #(
  parameter int SCREEN_W   = 320,
  parameter int ENEMY_W    = 16,
  parameter int ENEMY_H    = 16,
  parameter int SHOT_W     = 4,
  parameter int SHOT_H     = 8,
  parameter int PLAYER_W   = 16,
  parameter int PLAYER_H   = 16,
  parameter int LIVES_INIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [8:0]  enemy_x,
  input  logic [8:0]  enemy_y,
  input  logic        enemy_avoided,
  input  logic [8:0]  shot_x,
  input  logic [8:0]  shot_y,
  input  logic        shot_valid,
  input  logic [8:0]  player_x,
  input  logic [8:0]  player_y,
  output logic        colision,
  output logic        shot_hit,
  output logic [1:0]  scene,
  output logic [15:0] score_bcd,
  output logic [1:0]  lives
);
  typedef enum logic [1:0] {TITLE = 2'd0, PLAY = 2'd1, GAMEOVER = 2'd2} scene_t;
  scene_t st;
  logic start_q, start_rise, active, hit_s, hit_p, c;
  logic [1:0] dec, lives_nxt;
  logic [3:0] d;
  logic [15:0] score_inc;
  // Widened to 10 bits so edge sums near 511 cannot wrap.
  function automatic logic overlap(input logic [9:0] ax, ay, aw, ah, bx, by, bw, bh);
    return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  endfunction
  assign scene      = st;
  assign start_rise = start & ~start_q;
  assign active     = {1'b0, enemy_x} < 10'(SCREEN_W);
  assign hit_s      = frame_tick & shot_valid & active &
                      overlap({1'b0, shot_x}, {1'b0, shot_y}, 10'(SHOT_W), 10'(SHOT_H),
                              {1'b0, enemy_x}, {1'b0, enemy_y}, 10'(ENEMY_W), 10'(ENEMY_H));
  assign hit_p      = frame_tick & active & ~hit_s &
                      overlap({1'b0, player_x}, {1'b0, player_y}, 10'(PLAYER_W), 10'(PLAYER_H),
                              {1'b0, enemy_x}, {1'b0, enemy_y}, 10'(ENEMY_W), 10'(ENEMY_H));
  assign dec        = {1'b0, hit_p} + {1'b0, enemy_avoided};
  assign lives_nxt  = lives > dec ? lives - dec : 2'd0;
  always_comb begin
    score_inc = score_bcd;
    c = 1'b1;
    d = 4'd0;
    for (int i = 0; i < 4; i++) begin
      d = score_bcd[4*i +: 4];
      score_inc[4*i +: 4] = c ? (d == 4'd9 ? 4'd0 : d + 4'd1) : d;
      c = c & (d == 4'd9);
    end
    score_inc = score_bcd == 16'h9999 ? score_bcd : score_inc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= TITLE;
      score_bcd <= 16'h0000;
      lives     <= 2'(LIVES_INIT);
      colision  <= 1'b0;
      shot_hit  <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      start_q  <= start;
      colision <= 1'b0;
      shot_hit <= 1'b0;
      case (st)
        TITLE: if (start_rise) begin
          st        <= PLAY;
          score_bcd <= 16'h0000;
          lives     <= 2'(LIVES_INIT);
        end
        PLAY: if (lives == 2'd0) st <= GAMEOVER;
        else begin
          colision  <= hit_s | hit_p;
          shot_hit  <= hit_s;
          score_bcd <= hit_s ? score_inc : score_bcd;
          lives     <= lives_nxt;
        end
        GAMEOVER: if (start_rise) st <= TITLE;
        default: st <= TITLE;
      endcase
    end
  end
endmodule

// File: tb/tb_collision_scorer.sv
// tb_collision_scorer: directed vectors with hand-computed expectations for collision_scorer.
module tb_collision_scorer;
  logic clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, start = 1'b0;
  logic [8:0] enemy_x = 9'd0, enemy_y = 9'd0, shot_x = 9'd0, shot_y = 9'd0;
  logic [8:0] player_x = 9'd0, player_y = 9'd0;
  logic enemy_avoided = 1'b0, shot_valid = 1'b0;
  logic colision, shot_hit;
  logic [1:0] scene, lives;
  logic [15:0] score_bcd;
  int checks = 0, errors = 0;
  collision_scorer dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_avoided(enemy_avoided),
    .shot_x(shot_x), .shot_y(shot_y), .shot_valid(shot_valid),
    .player_x(player_x), .player_y(player_y),
    .colision(colision), .shot_hit(shot_hit), .scene(scene),
    .score_bcd(score_bcd), .lives(lives)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic pos(input logic [8:0] ex, ey, sx, sy, px, py, input logic sv);
    enemy_x = ex; enemy_y = ey; shot_x = sx; shot_y = sy;
    player_x = px; player_y = py; shot_valid = sv;
  endtask
  initial begin
    pos(9'd100, 9'd50, 9'd104, 9'd60, 9'd0, 9'd0, 1'b1);
    repeat (2) tick();
    chk("rst_scene", scene, 0);
    chk("rst_score", score_bcd, 0);
    chk("rst_lives", lives, 3);
    chk("rst_col", colision, 0);
    chk("rst_shot", shot_hit, 0);
    rst_n = 1'b1;
    frame_tick = 1'b1;
    tick();
    chk("title_ft_col", colision, 0);
    frame_tick = 1'b0;
    start = 1'b1;
    tick();
    chk("start_scene", scene, 1);
    chk("start_lives", lives, 3);
    chk("start_score", score_bcd, 0);
    repeat (4) tick();
    chk("start_hold", scene, 1);
    start = 1'b0;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("shot_col", colision, 1);
    chk("shot_hit", shot_hit, 1);
    chk("shot_score", score_bcd, 16'h0001);
    tick();
    chk("shot_col_end", colision, 0);
    chk("shot_hit_end", shot_hit, 0);
    tick();
    chk("noft_col", colision, 0);
    chk("noft_score", score_bcd, 16'h0001);
    pos(9'd100, 9'd200, 9'd0, 9'd0, 9'd110, 9'd210, 1'b0);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("crash_col", colision, 1);
    chk("crash_shot", shot_hit, 0);
    chk("crash_lives", lives, 2);
    pos(9'd100, 9'd200, 9'd104, 9'd204, 9'd110, 9'd210, 1'b1);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("both_col", colision, 1);
    chk("both_shot", shot_hit, 1);
    chk("both_lives", lives, 2);
    chk("both_score", score_bcd, 16'h0002);
    pos(9'd400, 9'd200, 9'd404, 9'd204, 9'd404, 9'd200, 1'b1);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("park_col", colision, 0);
    chk("park_lives", lives, 2);
    chk("park_score", score_bcd, 16'h0002);
    pos(9'd100, 9'd50, 9'd116, 9'd60, 9'd0, 9'd0, 1'b1);
    frame_tick = 1'b1;
    tick();
    chk("edge_out_col", colision, 0);
    chk("edge_out_shot", shot_hit, 0);
    shot_x = 9'd115;
    tick();
    frame_tick = 1'b0;
    chk("edge_in_shot", shot_hit, 1);
    chk("edge_in_score", score_bcd, 16'h0003);
    enemy_avoided = 1'b1;
    tick();
    enemy_avoided = 1'b0;
    chk("avoid_lives", lives, 1);
    chk("avoid_col", colision, 0);
    pos(9'd100, 9'd200, 9'd0, 9'd0, 9'd110, 9'd210, 1'b0);
    frame_tick = 1'b1;
    enemy_avoided = 1'b1;
    tick();
    frame_tick = 1'b0;
    enemy_avoided = 1'b0;
    chk("last_lives", lives, 0);
    chk("last_col", colision, 1);
    chk("last_scene", scene, 1);
    tick();
    chk("over_scene", scene, 2);
    chk("over_col", colision, 0);
    pos(9'd100, 9'd50, 9'd104, 9'd60, 9'd0, 9'd0, 1'b1);
    frame_tick = 1'b1;
    enemy_avoided = 1'b1;
    tick();
    frame_tick = 1'b0;
    enemy_avoided = 1'b0;
    chk("over_ft_col", colision, 0);
    chk("over_score", score_bcd, 16'h0003);
    chk("over_lives", lives, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("title_scene", scene, 0);
    chk("title_score", score_bcd, 16'h0003);
    tick();
    start = 1'b1;
    tick();
    chk("replay_scene", scene, 1);
    chk("replay_score", score_bcd, 0);
    chk("replay_lives", lives, 3);
    frame_tick = 1'b1;
    repeat (99) tick();
    chk("score_99", score_bcd, 16'h0099);
    tick();
    chk("score_100", score_bcd, 16'h0100);
    repeat (9899) tick();
    chk("score_9999", score_bcd, 16'h9999);
    tick();
    chk("sat_score", score_bcd, 16'h9999);
    chk("sat_shot", shot_hit, 1);
    chk("sat_lives", lives, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_scene", scene, 0);
    chk("arst_score", score_bcd, 0);
    chk("arst_lives", lives, 3);
    chk("arst_col", colision, 0);
    chk("arst_shot", shot_hit, 0);
    frame_tick = 1'b0;
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    chk("post_rst_start", scene, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/collision_scorer.md
Name: collision_scorer

Overview:
- Game-rule stage directly downstream of the enemy sprite block.
- Consumes the enemy position and avoided flag, plus shot and player positions.
- Produces the `colision` pulse and `scene` code that feed back into the enemy block.
- Tracks score (BCD) and lives, and sequences TITLE / PLAY / GAMEOVER.

Parameters:
- SCREEN_W, 320: enemy_x >= SCREEN_W means enemy inactive/parked; never collides.
- ENEMY_W, 16: enemy box width in pixels.
- ENEMY_H, 16: enemy box height in pixels.
- SHOT_W, 4: shot box width.
- SHOT_H, 8: shot box height.
- PLAYER_W, 16: player box width.
- PLAYER_H, 16: player box height.
- LIVES_INIT, 3: lives loaded on entry to PLAY (1..3).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle strobe, once per frame; collision sample point
- start  in  1  debounced start button level
- enemy_x  in  9  enemy top-left X
- enemy_y  in  9  enemy top-left Y
- enemy_avoided  in  1  one-cycle pulse: enemy left screen bottom
- shot_x  in  9  shot top-left X
- shot_y  in  9  shot top-left Y
- shot_valid  in  1  shot currently in flight
- player_x  in  9  player top-left X
- player_y  in  9  player top-left Y
- colision  out  1  one-cycle pulse to enemy block: enemy destroyed
- shot_hit  out  1  one-cycle pulse: shot consumed
- scene  out  2  0=TITLE, 1=PLAY, 2=GAMEOVER (3 unused)
- score_bcd  out  16  4-digit packed BCD score
- lives  out  2  remaining lives

Behaviour:
- One clock `clk`; reset is asynchronous, active-low on `rst_n`.
- Reset values (applied immediately on rst_n low, mid-operation included): scene=0, score_bcd=0, lives=LIVES_INIT, colision=0, shot_hit=0, start edge register=0.
- Start edge: start_rise = start & ~start_q. start_q is registered each clk. Holding start produces exactly one rise.
- FSM:
  - TITLE: on start_rise -> PLAY; score cleared to 0, lives=LIVES_INIT, same edge.
  - PLAY: evaluates collisions and avoided events. When lives reaches 0 -> GAMEOVER on the next edge.
  - GAMEOVER: score and lives held. On start_rise -> TITLE.
  - Code 3 unreachable. If forced there, return to TITLE next edge.
- Overlap test, all arithmetic 10-bit zero-extended (no wrap): A,B overlap iff ax < bx+BW and bx < ax+AW and ay < by+BH and by < ay+AH.
- enemy_active = (enemy_x < SCREEN_W).
- Shot hit, evaluated in PLAY on a cycle with frame_tick=1: hit_s = shot_valid & enemy_active & overlap(shot, enemy).
- Player crash, same cycle: hit_p = enemy_active & overlap(player, enemy) & ~hit_s. Shot wins a simultaneous frame; no life lost.
- Outputs are registered, latency 1: edge after the frame_tick cycle, colision = hit_s | hit_p for exactly one cycle; shot_hit = hit_s for one cycle.
- Same edge:
  - hit_s: score +1 in BCD with per-digit carry; saturates at 9999.
  - hit_p: lives -1.
- enemy_avoided pulse in PLAY, any cycle: lives -1.
- Life decrements from hit_p and enemy_avoided on the same edge sum (-2). Lives saturate at 0.
- Outside PLAY: frame_tick and enemy_avoided ignored; colision and shot_hit stay 0.
- No collision evaluated on cycles without frame_tick. Inputs need only be stable in the frame_tick cycle.
- Once parked (enemy_x >= SCREEN_W) the enemy cannot re-trigger. This guarantees one colision per enemy instance.
- Transition to GAMEOVER occurs on the edge after lives becomes 0. A colision pulse issued on the same edge as the final decrement is still delivered.

Test Plan:
- Reset, then start held high 5 cycles -> scene 0->1 once; lives=3, score_bcd=0x0000; no second transition.
- PLAY, enemy (100,50), shot (104,60) valid, frame_tick 1 cycle:
  - next cycle colision=1 and shot_hit=1 for 1 cycle; score_bcd=0x0001.
  - same positions with frame_tick low -> no pulses.
- Player crash and simultaneous events:
  - enemy (100,200), player (110,210), shot invalid, frame_tick -> colision=1, shot_hit=0, lives 3->2.
  - repeat with a valid overlapping shot -> lives unchanged, score +1.
- Parked enemy and boundary: enemy_x=400 overlapping nothing after clipping -> no colision. Boundary: shot_x = enemy_x+ENEMY_W exactly -> no hit.
- Lives and game over:
  - lives=1, enemy_avoided and player crash resolved on same edge -> lives=0 (saturated), next edge scene=2.
  - start_rise -> scene=0, score held until next PLAY entry.
- Score saturation and reset:
  - score preloaded via 9999 hits path: 0x0099 +1 -> 0x0100; at 0x9999 a further hit keeps 0x9999.
  - rst_n pulsed low mid-PLAY -> all outputs at reset values without waiting for clk.
